// File: rtl/fifo_pkg.sv
// Shared definitions for the word packer: default geometry and packer FSM state codes.
package fifo_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_LANES = 4;

  typedef logic [1:0] state_t;

  localparam state_t FILL       = 2'd0;
  localparam state_t FLUSH_WAIT = 2'd1;
  localparam state_t FLUSH_EMIT = 2'd2;

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bundle between the upstream FIFO, the packer and the downstream consumer.
interface fifo_word_packer_if
  import fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int LANES = DEF_LANES
) ();

  logic                  rst_n;
  logic                  empty;
  logic [DW-1:0]         dataout;
  logic                  r_en;
  logic                  flush;
  logic [DW*LANES-1:0]   m_data;
  logic [LANES-1:0]      m_keep;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  empty, dataout, flush, m_ready,
    output r_en, m_data, m_keep, m_valid
  );

  modport slave (
    output rst_n, empty, dataout, flush, m_ready,
    input  r_en, m_data, m_keep, m_valid
  );

endinterface

// File: rtl/fifo_word_packer_pack_out_reg.sv
// Output holding register: captures a packed word on load and holds it until accepted.
module pack_out_reg #(
  parameter int DW    = 8,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [DW*LANES-1:0] data_i,
  input  logic [LANES-1:0]    keep_i,
  input  logic                ready_i,
  output logic [DW*LANES-1:0] data_o,
  output logic [LANES-1:0]    keep_o,
  output logic                valid_o,
  output logic                free_o
);

  logic [DW*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]    keep_q, keep_d;
  logic                valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      keep_d  = keep_i;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign valid_o = valid_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/sync_fifo.sv
// Simple synchronous FIFO with registered read data (valid the cycle after rd_en).
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic [DW-1:0] dout_q;
  logic          doWr, doRd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign doWr  = wr_en && !full;
  assign doRd  = rd_en && !empty;
  assign dout  = dout_q;

  always_ff @(posedge clk) begin
    if (doWr) mem[wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      if (doWr) wptr_q <= wptr_q + 1'b1;
      if (doRd) begin
        rptr_q <= rptr_q + 1'b1;
        dout_q <= mem[rptr_q];
      end
      cnt_q <= cnt_q + (AW+1)'(doWr) - (AW+1)'(doRd);
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs LANES consecutive FIFO entries into one output word; flush emits a partial word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int LANES = DEF_LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_word_packer_if.master bus,
  output logic [15:0]        words_out
);

  localparam int FW = $clog2(LANES + 1);
  localparam logic [FW:0]   LANES_O = (FW+1)'(LANES);
  localparam logic [FW-1:0] LANES_F = FW'(LANES);

  state_t              state_q, state_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic                pend_q;
  logic                run_q;
  logic [DW*LANES-1:0] acc_q, acc_d;
  logic [15:0]         wcount_q, wcount_d;

  logic                slotFree, moveNow, flushMove, load, rdEn;
  logic [FW:0]         occ, occEff;
  logic [FW-1:0]       lane;
  logic [LANES-1:0]    keepMask;

  // A read at occupancy LANES is allowed only when the slot is free now, which
  // guarantees the full accumulator can move out on the very cycle the byte lands.
  always_comb begin
    occ       = {1'b0, fill_q} + {{FW{1'b0}}, pend_q};
    moveNow   = (state_q == FILL) && (fill_q == LANES_F) && slotFree;
    flushMove = (state_q == FLUSH_EMIT) && (fill_q != '0) && slotFree;
    load      = moveNow || flushMove;
    occEff    = moveNow ? (occ - LANES_O) : occ;
    rdEn      = run_q && !bus.empty && !bus.flush && (state_q == FILL) &&
                ((occEff < LANES_O) || ((occEff == LANES_O) && slotFree));
    for (int i = 0; i < LANES; i++) keepMask[i] = (i < int'(fill_q));
  end

  always_comb begin
    acc_d  = load ? '0 : acc_q;
    lane   = load ? '0 : fill_q;
    fill_d = (load ? '0 : fill_q) + FW'(pend_q);
    if (pend_q) acc_d[int'(lane)*DW +: DW] = bus.dataout;
    wcount_d = wcount_q + 16'(bus.m_valid && bus.m_ready);
    state_d  = state_q;
    case (state_q)
      FILL:       if (bus.flush) state_d = FLUSH_WAIT;
      FLUSH_WAIT: if (!pend_q) state_d = FLUSH_EMIT;
      FLUSH_EMIT: if ((fill_q == '0) || slotFree) state_d = FILL;
      default:    state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      fill_q   <= '0;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
      acc_q    <= '0;
      wcount_q <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      pend_q   <= rdEn;
      run_q    <= 1'b1;
      acc_q    <= acc_d;
      wcount_q <= wcount_d;
    end
  end

  pack_out_reg #(.DW(DW), .LANES(LANES)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .data_i  (acc_q),
    .keep_i  (keepMask),
    .ready_i (bus.m_ready),
    .data_o  (bus.m_data),
    .keep_o  (bus.m_keep),
    .valid_o (bus.m_valid),
    .free_o  (slotFree)
  );

  assign bus.r_en  = rdEn;
  assign words_out = wcount_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer fed by a sync_fifo; a byte-queue model predicts every output word.
module tb_fifo_word_packer;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrEn;
  logic [7:0]  din;
  logic        fifoFull;
  logic [15:0] wordsOut;

  always #5 clk = ~clk;

  fifo_word_packer_if #(.DW(8), .LANES(4)) bus ();

  assign bus.rst_n = rst_n;

  sync_fifo #(8, 16) upstream (
    .clk   (clk),
    .rst_n (bus.rst_n),
    .wr_en (wrEn),
    .din   (din),
    .rd_en (bus.r_en),
    .dout  (bus.dataout),
    .empty (bus.empty),
    .full  (fifoFull)
  );

  fifo_word_packer #(.DW(8), .LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .words_out (wordsOut)
  );

  int          total = 0;
  int          bad = 0;
  int          modelWords = 0;
  logic [7:0]  byteQ [$];
  logic [35:0] expQ [$];
  logic        stallPrev = 1'b0;
  logic [31:0] prevData = '0;
  logic [3:0]  prevKeep = '0;
  logic [35:0] monE;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [31:0] w, input logic [3:0] k);
    expQ.push_back({k, w});
    modelWords++;
  endtask

  // Every four bytes written in order form one full word, lane 0 in the LSBs.
  task automatic modelByte(input logic [7:0] b);
    byteQ.push_back(b);
    if (byteQ.size() == 4) begin
      pushWord({byteQ[3], byteQ[2], byteQ[1], byteQ[0]}, 4'hF);
      byteQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic doWrite, input logic [7:0] b, input logic ready);
    @(posedge clk); #1;
    wrEn = doWrite && !fifoFull;
    din = b;
    bus.m_ready = ready;
    if (doWrite && !fifoFull) modelByte(b);
  endtask

  task automatic applyFlush();
    logic [31:0] w;
    logic [3:0]  k;
    @(posedge clk); #1;
    wrEn = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (byteQ.size() > 0) begin
      w = '0;
      for (int i = 0; i < byteQ.size(); i++) w[8*i +: 8] = byteQ[i];
      k = 4'((1 << byteQ.size()) - 1);
      pushWord(w, k);
      byteQ.delete();
    end
  endtask

  task automatic waitDrain(input int limit);
    int   quiet;
    logic done;
    @(posedge clk); #1;
    wrEn = 1'b0;
    bus.m_ready = 1'b1;
    quiet = 0;
    done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge clk);
      if (bus.empty && !bus.r_en && !bus.m_valid && expQ.size() == 0) quiet++;
      else quiet = 0;
      if (quiet >= 3) done = 1'b1;
    end
    checkOutput("drainDone", 32'(done), 32'd1);
    checkOutput("wordsOutVsModel", 32'(wordsOut), 32'(16'(modelWords)));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("rEnWhileEmpty", 32'(bus.r_en && bus.empty), 32'd0);
      if (stallPrev) begin
        checkOutput("holdData", bus.m_data, prevData);
        checkOutput("holdKeep", 32'(bus.m_keep), 32'(prevKeep));
      end
      if (bus.m_valid && bus.m_ready) begin
        checkOutput("wordExpected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          monE = expQ.pop_front();
          checkOutput("wordData", bus.m_data, monE[31:0]);
          checkOutput("wordKeep", 32'(bus.m_keep), 32'(monE[35:32]));
        end
      end
      stallPrev = bus.m_valid && !bus.m_ready;
      prevData = bus.m_data;
      prevKeep = bus.m_keep;
    end else begin
      stallPrev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  t1 [4];
    logic [7:0]  t3 [3];
    logic [15:0] wo;
    int          got;
    int          target;

    t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    t3 = '{8'hA1, 8'hB2, 8'hC3};
    rst_n = 1'b0;
    wrEn = 1'b0;
    din = '0;
    bus.flush = 1'b0;
    bus.m_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("resetREn", 32'(bus.r_en), 32'd0);
    checkOutput("resetValid", 32'(bus.m_valid), 32'd0);
    checkOutput("resetData", bus.m_data, 32'd0);
    checkOutput("resetKeep", 32'(bus.m_keep), 32'd0);
    checkOutput("resetWords", 32'(wordsOut), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] single full word");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, t1[i], 1'b1);
    waitDrain(100);
    checkOutput("t1Words", 32'(wordsOut), 32'd1);

    $display("[TB] two words under backpressure");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    for (int s = 0; s < 10; s++) begin
      applyStimulus(s < 2, 8'(8'h09 + s), 1'b0);
      @(negedge clk);
      if (s >= 2) checkOutput("stallNoRead", 32'(bus.r_en), 32'd0);
    end
    waitDrain(100);
    applyFlush();
    waitDrain(100);

    $display("[TB] partial word flush");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, t3[i], 1'b1);
    waitDrain(100);
    applyFlush();
    waitDrain(100);
    checkOutput("t3State", 32'(dut.state_q), 32'(FILL));

    $display("[TB] empty flush");
    wo = wordsOut;
    applyFlush();
    repeat (6) begin
      @(negedge clk);
      checkOutput("t4NoValid", 32'(bus.m_valid), 32'd0);
    end
    checkOutput("t4Words", 32'(wordsOut), 32'(wo));

    $display("[TB] full-rate drain of a full FIFO");
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("t5FifoFull", 32'(fifoFull), 32'd1);
    target = int'(wordsOut) + 6;
    applyStimulus(1'b0, 8'h00, 1'b1);
    got = 0;
    for (int c = 1; c <= 30 && got == 0; c++) begin
      @(posedge clk); #1;
      if (int'(wordsOut) == target) got = c;
    end
    checkOutput("t5WithinBudget", 32'(got > 0 && got <= 21), 32'd1);
    waitDrain(100);

    $display("[TB] reset in the middle of a read");
    applyStimulus(1'b1, 8'h55, 1'b1);
    applyStimulus(1'b1, 8'h66, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.r_en) break;
    end
    rst_n = 1'b0;
    wrEn = 1'b0;
    byteQ.delete();
    expQ.delete();
    modelWords = 0;
    @(negedge clk);
    checkOutput("midResetREn", 32'(bus.r_en), 32'd0);
    checkOutput("midResetValid", 32'(bus.m_valid), 32'd0);
    checkOutput("midResetWords", 32'(wordsOut), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b1);
    waitDrain(100);
    checkOutput("t6Words", 32'(wordsOut), 32'd1);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 600; it++) begin
      applyStimulus($urandom_range(99) < 55, 8'($urandom), $urandom_range(99) < 70);
      if (it % 150 == 149) begin
        waitDrain(200);
        applyFlush();
        waitDrain(200);
      end
    end
    waitDrain(200);
    applyFlush();
    waitDrain(200);
    checkOutput("finalWords", 32'(wordsOut), 32'(16'(modelWords)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
